// File: rtl/boot_cmd_sequencer.sv
// Boot command sequencer: UART-framed opcodes drive LEDs, SPI flash bytes and a version query.
// Optional inter-byte timeout abort is built when BOOT_SEQ_TIMEOUT_EN is defined.
module boot_cmd_sequencer #(
    parameter int          TIMEOUT_CYCLES = 12000,
    parameter logic [7:0]  VERSION        = 8'h01
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [7:0] tx_data,
    output logic       spi_start,
    output logic [7:0] spi_wdata,
    input  logic       spi_done,
    input  logic [7:0] spi_rdata,
    output logic       spi_cs_n,
    output logic [4:0] leds
);

    typedef enum logic [2:0] {
        IDLE, GET_LEN, LED, SPI_ISSUE, SPI_WAIT, SPI_ECHO, DRAIN, RESP
    } state_t;

    state_t     state;
    logic [7:0] fifo_mem [4];
    logic [1:0] wr_ptr, rd_ptr;
    logic [2:0] fifo_count;
    logic       fifo_empty, fifo_full, push, pop;
    logic [7:0] head;
    logic [7:0] opcode, remaining;
    logic       first_byte, unknown_op, ver_pending, aborted, overrun;
    logic       timeout_hit;

    assign fifo_empty = (fifo_count == 3'd0);
    assign fifo_full  = (fifo_count == 3'd4);
    assign head       = fifo_mem[rd_ptr];
    assign push       = rx_valid && (!fifo_full || pop);

    // Any byte still offered to the UART stalls all consumption of the FIFO.
    always_comb begin
        pop = 1'b0;
        if (!fifo_empty && !tx_valid &&
            (state inside {IDLE, GET_LEN, LED, SPI_ISSUE, DRAIN}))
            pop = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= 2'd0;
            rd_ptr     <= 2'd0;
            fifo_count <= 3'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= rx_data;
                wr_ptr           <= wr_ptr + 2'd1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 2'd1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 3'd1;
                2'b01:   fifo_count <= fifo_count - 3'd1;
                default: ;
            endcase
        end
    end

`ifdef BOOT_SEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_count;
    logic            counting;

    assign counting    = fifo_empty && (state != IDLE) && (state != RESP);
    assign timeout_hit = counting && (to_count == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset || !counting || timeout_hit)
            to_count <= '0;
        else
            to_count <= to_count + 1'b1;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            tx_valid    <= 1'b0;
            tx_data     <= 8'h00;
            spi_start   <= 1'b0;
            spi_wdata   <= 8'h00;
            spi_cs_n    <= 1'b1;
            leds        <= 5'b00000;
            opcode      <= 8'h00;
            remaining   <= 8'h00;
            first_byte  <= 1'b0;
            unknown_op  <= 1'b0;
            ver_pending <= 1'b0;
            aborted     <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            spi_start <= 1'b0;
            if (tx_valid && tx_ready)
                tx_valid <= 1'b0;

            if (timeout_hit) begin
                spi_cs_n    <= 1'b1;
                aborted     <= 1'b1;
                ver_pending <= 1'b0;
                state       <= RESP;
            end else begin
                case (state)
                    IDLE: if (pop) begin
                        opcode <= head;
                        state  <= GET_LEN;
                    end
                    GET_LEN: if (pop) begin
                        remaining   <= head;
                        first_byte  <= 1'b1;
                        unknown_op  <= 1'b0;
                        ver_pending <= 1'b0;
                        aborted     <= 1'b0;
                        case (opcode)
                            8'h01: state <= (head == 8'h00) ? RESP : LED;
                            8'h02: begin
                                if (head != 8'h00) begin
                                    spi_cs_n <= 1'b0;
                                    state    <= SPI_ISSUE;
                                end else begin
                                    state <= RESP;
                                end
                            end
                            8'h03: begin
                                ver_pending <= 1'b1;
                                state       <= (head == 8'h00) ? RESP : DRAIN;
                            end
                            default: begin
                                unknown_op <= 1'b1;
                                state      <= (head == 8'h00) ? RESP : DRAIN;
                            end
                        endcase
                    end
                    LED: if (pop) begin
                        if (first_byte)
                            leds <= head[4:0];
                        first_byte <= 1'b0;
                        remaining  <= remaining - 8'd1;
                        if (remaining == 8'd1)
                            state <= RESP;
                    end
                    DRAIN: if (pop) begin
                        remaining <= remaining - 8'd1;
                        if (remaining == 8'd1)
                            state <= RESP;
                    end
                    SPI_ISSUE: if (pop) begin
                        spi_start <= 1'b1;
                        spi_wdata <= head;
                        remaining <= remaining - 8'd1;
                        state     <= SPI_WAIT;
                    end
                    SPI_WAIT: if (spi_done) begin
                        tx_data  <= spi_rdata;
                        tx_valid <= 1'b1;
                        state    <= SPI_ECHO;
                    end
                    SPI_ECHO: if (tx_valid && tx_ready) begin
                        if (remaining == 8'd0) begin
                            spi_cs_n <= 1'b1;
                            state    <= RESP;
                        end else begin
                            state <= SPI_ISSUE;
                        end
                    end
                    RESP: if (!tx_valid) begin
                        tx_valid <= 1'b1;
                        if (ver_pending) begin
                            tx_data     <= VERSION;
                            ver_pending <= 1'b0;
                        end else begin
                            if (aborted)
                                tx_data <= 8'hEF;
                            else if (overrun)
                                tx_data <= 8'hE0;
                            else if (unknown_op)
                                tx_data <= 8'hEE;
                            else
                                tx_data <= 8'hA5;
                            if (!aborted)
                                overrun <= 1'b0;
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end

            // A drop in this cycle must survive the clear performed by an E0 response.
            if (rx_valid && fifo_full && !pop)
                overrun <= 1'b1;
        end
    end

endmodule
